wb_sram_2mx8_ctrl: RTL

Wishbone classic slave that bridges the Amber system bus (32-bit data, byte selects) to the board's external asynchronous SRAM bank: four 2Mx8 devices with shared 21-bit address, shared 8-bit data bus, common read/write strobes and one active-low chip select per device. It sits directly downstream of the system's Wishbone interconnect and drives the SRAM pins of the top level. Each 32-bit access is serialised into up to four byte cycles with programmable strobe width.

---
 rtl/wb_sram_2mx8_ctrl_pkg.sv | 16 +
 rtl/wb_sram_2mx8_ctrl.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/wb_sram_2mx8_ctrl_pkg.sv
// Shared definitions for the Wishbone to 4x 2Mx8 asynchronous SRAM bridge.
package wb_sram_2mx8_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_STROBE = 3'd2,
        ST_HOLD   = 3'd3,
        ST_ACK    = 3'd4
    } state_t;

    localparam int NUM_DEVICES     = 4;
    localparam int DEV_ADDR_W      = 21;
    localparam int DEF_WAIT_CYCLES = 2;

endpackage

// File: rtl/wb_sram_2mx8_ctrl.sv
// Wishbone classic slave serialising 32-bit accesses into byte cycles on an
// external bank of four 2Mx8 asynchronous SRAMs sharing address and data pins.
module wb_sram_2mx8_ctrl
    import wb_sram_2mx8_ctrl_pkg::*;
#(
    parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
)(
    input  logic                   i_clk,
    input  logic                   i_reset_n,
    input  logic [31:0]            i_wb_adr,
    input  logic [3:0]             i_wb_sel,
    input  logic                   i_wb_we,
    input  logic [31:0]            i_wb_dat,
    output logic [31:0]            o_wb_dat,
    input  logic                   i_wb_cyc,
    input  logic                   i_wb_stb,
    output logic                   o_wb_ack,
    output logic                   o_wb_err,
    output logic [NUM_DEVICES-1:0] o_sram_cs_n,
    output logic                   o_sram_read_n,
    output logic                   o_sram_write_n,
    output logic [DEV_ADDR_W-1:0]  o_sram_addr,
    inout  wire  [7:0]             io_sram_data
);

    state_t                  r_state;
    logic [1:0]              r_lane;
    logic [3:0]              r_cnt;
    logic [20:0]             r_adr;
    logic [3:0]              r_sel;
    logic                    r_we;
    logic [31:0]             r_dat;
    logic [31:0]             r_buf;
    logic [31:0]             r_wb_dat;
    logic                    r_ack;
    logic [NUM_DEVICES-1:0]  r_cs_n;
    logic                    r_rd_n;
    logic                    r_wr_n;
    logic [DEV_ADDR_W-1:0]   r_sram_addr;
    logic                    r_oe;
    logic [7:0]              r_dout;

    state_t                  w_state_nxt;
    logic [1:0]              w_lane_nxt;
    logic [3:0]              w_cnt_nxt;
    logic [2:0]              w_pick;
    logic                    w_req;
    logic [20:0]             w_adr_nxt;
    logic                    w_we_nxt;
    logic [31:0]             w_dat_nxt;
    logic                    w_busy_nxt;
    logic [1:0]              w_dev;
    logic [7:0]              w_byte;
    logic                    w_unused;

    // Lowest selected lane at or above start; bit 2 set means none remain.
    function automatic logic [2:0] f_next_lane(input logic [3:0] sel, input logic [2:0] start);
        logic [2:0] res;
        res = 3'b100;
        for (int i = 3; i >= 0; i--) begin
            if (sel[i] && (3'(i) >= start)) res = 3'(i);
        end
        return res;
    endfunction

    assign w_unused = ^{i_wb_adr[31:23], i_wb_adr[1:0]};
    assign w_req    = i_wb_cyc && i_wb_stb;

    always_comb begin
        w_state_nxt = r_state;
        w_lane_nxt  = r_lane;
        w_cnt_nxt   = r_cnt;
        w_pick      = (r_state == ST_IDLE) ? f_next_lane(i_wb_sel, 3'd0)
                                           : f_next_lane(r_sel, {1'b0, r_lane} + 3'd1);
        case (r_state)
            ST_IDLE: begin
                if (w_req) begin
                    if (w_pick[2]) begin
                        w_state_nxt = ST_ACK;
                    end else begin
                        w_state_nxt = ST_SETUP;
                        w_lane_nxt  = w_pick[1:0];
                    end
                end
            end
            ST_SETUP: begin
                w_state_nxt = ST_STROBE;
                w_cnt_nxt   = 4'(WAIT_CYCLES - 1);
            end
            ST_STROBE: begin
                if (r_cnt == 4'd0) w_state_nxt = ST_HOLD;
                else               w_cnt_nxt   = r_cnt - 4'd1;
            end
            ST_HOLD: begin
                if (w_pick[2]) begin
                    w_state_nxt = ST_ACK;
                end else begin
                    w_state_nxt = ST_SETUP;
                    w_lane_nxt  = w_pick[1:0];
                end
            end
            ST_ACK:  w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Pin registers are loaded from the next state so every pin changes on
    // the same edge as the state it belongs to.
    assign w_adr_nxt  = (r_state == ST_IDLE) ? i_wb_adr[22:2] : r_adr;
    assign w_we_nxt   = (r_state == ST_IDLE) ? i_wb_we        : r_we;
    assign w_dat_nxt  = (r_state == ST_IDLE) ? i_wb_dat       : r_dat;
    assign w_busy_nxt = (w_state_nxt == ST_SETUP) || (w_state_nxt == ST_STROBE) ||
                        (w_state_nxt == ST_HOLD);
    assign w_dev      = w_adr_nxt[20:19];
    assign w_byte     = w_dat_nxt[{w_lane_nxt, 3'b000} +: 8];

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state     <= ST_IDLE;
            r_lane      <= 2'd0;
            r_cnt       <= 4'd0;
            r_adr       <= '0;
            r_sel       <= '0;
            r_we        <= 1'b0;
            r_dat       <= '0;
            r_buf       <= '0;
            r_wb_dat    <= '0;
            r_ack       <= 1'b0;
            r_cs_n      <= '1;
            r_rd_n      <= 1'b1;
            r_wr_n      <= 1'b1;
            r_sram_addr <= '0;
            r_oe        <= 1'b0;
            r_dout      <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_lane  <= w_lane_nxt;
            r_cnt   <= w_cnt_nxt;
            if (r_state == ST_IDLE && w_req) begin
                r_adr <= i_wb_adr[22:2];
                r_sel <= i_wb_sel;
                r_we  <= i_wb_we;
                r_dat <= i_wb_dat;
                r_buf <= '0;
            end else if (r_state == ST_STROBE && r_cnt == 4'd0 && !r_we) begin
                r_buf[{r_lane, 3'b000} +: 8] <= io_sram_data;
            end
            r_cs_n      <= w_busy_nxt ? ~(4'b0001 << w_dev) : 4'hF;
            r_sram_addr <= w_busy_nxt ? {w_adr_nxt[18:0], w_lane_nxt} : r_sram_addr;
            r_rd_n      <= !(w_state_nxt == ST_STROBE && !r_we);
            r_wr_n      <= !(w_state_nxt == ST_STROBE && r_we);
            r_oe        <= w_busy_nxt && w_we_nxt;
            r_dout      <= w_busy_nxt ? w_byte : r_dout;
            r_ack       <= (w_state_nxt == ST_ACK);
            if (w_state_nxt == ST_ACK) r_wb_dat <= (r_state == ST_IDLE) ? 32'd0 : r_buf;
        end
    end

    assign o_wb_dat       = r_wb_dat;
    assign o_wb_ack       = r_ack;
    assign o_wb_err       = 1'b0;
    assign o_sram_cs_n    = r_cs_n;
    assign o_sram_read_n  = r_rd_n;
    assign o_sram_write_n = r_wr_n;
    assign o_sram_addr    = r_sram_addr;
    assign io_sram_data   = r_oe ? r_dout : 8'bz;

endmodule
